// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the memory-stage initiator, responder and hazard logic.
package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [63:0] MEM_LIMIT_DEFAULT = 64'd8192;

    // Address / write-data operand selects produced by the decoder.
    localparam logic ADDR_SEL_VALE = 1'b0;
    localparam logic ADDR_SEL_VALA = 1'b1;
    localparam logic DATA_SEL_VALA = 1'b0;
    localparam logic DATA_SEL_VALP = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StErr
    } mem_state_e;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational icode decode into data-memory access kind and operand selects.
module mem_access_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic       o_is_rd,
    output logic       o_is_wr,
    output logic       o_addr_sel,
    output logic       o_data_sel
);

    always_comb begin
        o_is_rd    = 1'b0;
        o_is_wr    = 1'b0;
        o_addr_sel = ADDR_SEL_VALE;
        o_data_sel = DATA_SEL_VALA;
        case (i_icode)
            IRMMOVQ: o_is_wr = 1'b1;
            IMRMOVQ: o_is_rd = 1'b1;
            ICALL: begin
                o_is_wr    = 1'b1;
                o_data_sel = DATA_SEL_VALP;
            end
            IRET: begin
                o_is_rd    = 1'b1;
                o_addr_sel = ADDR_SEL_VALA;
            end
            IPUSHQ:  o_is_wr = 1'b1;
            IPOPQ: begin
                o_is_rd    = 1'b1;
                o_addr_sel = ADDR_SEL_VALA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_initiator.sv
// Memory-stage initiator: turns a decoded command into a req/ack access with
// bounds checking and a request timeout; all outputs are registered.
module mem_access_initiator
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_LIMIT = MEM_LIMIT_DEFAULT,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] ValA,
    input  logic [63:0] ValE,
    input  logic [63:0] ValP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] ValM,
    output logic        adr_error
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_e       r_state, w_state_d;
    logic             r_mem_req, w_mem_req_d;
    logic             r_mem_we, w_mem_we_d;
    logic [63:0]      r_mem_addr, w_mem_addr_d;
    logic [63:0]      r_mem_wdata, w_mem_wdata_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;
    logic [63:0]      r_valm, w_valm_d;
    logic             r_adr_error, w_adr_error_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;

    logic             w_is_rd;
    logic             w_is_wr;
    logic             w_addr_sel;
    logic             w_data_sel;
    logic [63:0]      w_addr;
    logic [63:0]      w_wdata;

    mem_access_decode u_decode (
        .i_icode    (icode),
        .o_is_rd    (w_is_rd),
        .o_is_wr    (w_is_wr),
        .o_addr_sel (w_addr_sel),
        .o_data_sel (w_data_sel)
    );

    assign w_addr  = (w_addr_sel == ADDR_SEL_VALA) ? ValA : ValE;
    assign w_wdata = (w_data_sel == DATA_SEL_VALP) ? ValP : ValA;

    always_comb begin
        w_state_d     = r_state;
        w_mem_req_d   = r_mem_req;
        w_mem_we_d    = r_mem_we;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_done_d      = 1'b0;
        w_valm_d      = r_valm;
        w_adr_error_d = r_adr_error;
        w_cnt_d       = r_cnt;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_adr_error_d = 1'b0;
                    if (!(w_is_rd || w_is_wr)) begin
                        w_state_d = StDone;
                    end else if (w_addr > MEM_LIMIT) begin
                        w_state_d = StErr;
                    end else begin
                        w_state_d     = StReq;
                        w_mem_req_d   = 1'b1;
                        w_mem_we_d    = w_is_wr;
                        w_mem_addr_d  = w_addr;
                        w_mem_wdata_d = w_wdata;
                        w_cnt_d       = '0;
                    end
                end
            end
            StReq: begin
                // An ack arriving on the final timeout cycle still completes normally.
                if (mem_ack) begin
                    if (!r_mem_we) begin
                        w_valm_d = mem_rdata;
                    end
                    w_mem_req_d = 1'b0;
                    w_state_d   = StDone;
                end else if (r_cnt == CNT_LAST) begin
                    w_mem_req_d = 1'b0;
                    w_state_d   = StErr;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            StDone: begin
                w_done_d  = 1'b1;
                w_state_d = StIdle;
            end
            StErr: begin
                w_done_d      = 1'b1;
                w_adr_error_d = 1'b1;
                w_state_d     = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valm      <= '0;
            r_adr_error <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_valm      <= w_valm_d;
            r_adr_error <= w_adr_error_d;
            r_cnt       <= w_cnt_d;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ValM      = r_valm;
    assign adr_error = r_adr_error;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Scoreboard bench for mem_access_initiator with a scripted ack responder.
module tb_mem_access_initiator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] ValA;
    logic [63:0] ValE;
    logic [63:0] ValP;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [63:0] ValM;
    logic        adr_error;

    typedef struct {
        logic [63:0] valm;
        logic        err;
        int          done_cyc;
        int          reqs;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] m_valm;
    int          n_chk;
    int          n_err;

    mem_access_initiator #(
        .MEM_LIMIT (64'd8192),
        .TIMEOUT   (16),
        .CNT_W     (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .icode     (icode),
        .ValA      (ValA),
        .ValE      (ValE),
        .ValP      (ValP),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .ValM      (ValM),
        .adr_error (adr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one command, plays the responder (ack on REQ cycle ack_at, never if < 1),
    // optionally pulses start at cycle poke_at while busy, and scores the completion.
    task automatic run_cmd(input string name, input logic [3:0] ic, input logic [63:0] va,
                           input logic [63:0] ve, input logic [63:0] vp, input int ack_at,
                           input logic [63:0] rd, input int poke_at);
        exp_t        e;
        exp_t        got;
        bit          has_acc;
        bit          bad;
        int          reqs;
        int          dones;
        int          done_at;
        int          busy_bad;
        int          req_bad;
        logic        c_we;
        logic [63:0] c_addr;
        logic [63:0] c_wdata;

        has_acc = ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
        e.we    = ic inside {4'd4, 4'd8, 4'd10};
        e.addr  = (ic == 4'd9 || ic == 4'd11) ? va : ve;
        e.wdata = (ic == 4'd8) ? vp : va;
        bad     = has_acc && (e.addr > 64'd8192);
        if (!has_acc || bad) begin
            e.reqs     = 0;
            e.done_cyc = 2;
            e.err      = bad;
        end else if (ack_at >= 1 && ack_at <= 16) begin
            e.reqs     = ack_at;
            e.done_cyc = 2 + ack_at;
            e.err      = 1'b0;
            if (!e.we) m_valm = rd;
        end else begin
            e.reqs     = 16;
            e.done_cyc = 18;
            e.err      = 1'b1;
        end
        e.valm = m_valm;
        sb_q.push_back(e);

        @(posedge clk); #1;
        start = 1'b1; icode = ic; ValA = va; ValE = ve; ValP = vp;
        @(posedge clk); #1;
        // Scramble operands so only the values latched at start can matter.
        start = 1'b0; icode = 4'(($urandom % 16));
        ValA = {$urandom, $urandom}; ValE = {$urandom, $urandom}; ValP = {$urandom, $urandom};

        reqs = 0; dones = 0; done_at = 0; busy_bad = 0; req_bad = 0;
        c_we = 1'b0; c_addr = '0; c_wdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check_eq({name, "_busy"}, 64'(busy), 64'd1);
                check_eq({name, "_errclr"}, 64'(adr_error), 64'd0);
            end
            start = (c == poke_at);
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
                end else if (mem_we !== c_we || mem_addr !== c_addr || mem_wdata !== c_wdata) begin
                    req_bad++;
                end
            end
            if (mem_req && reqs == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end else begin
                mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
            end
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_at = c;
                    got = sb_q.pop_front();
                    check_eq({name, "_valm"}, ValM, got.valm);
                    check_eq({name, "_err"}, 64'(adr_error), 64'(got.err));
                    check_eq({name, "_lat"}, 64'(c), 64'(got.done_cyc));
                    check_eq({name, "_reqs"}, 64'(reqs), 64'(got.reqs));
                    if (got.reqs > 0) begin
                        check_eq({name, "_we"}, 64'(c_we), 64'(got.we));
                        check_eq({name, "_addr"}, c_addr, got.addr);
                        if (got.we) check_eq({name, "_wdata"}, c_wdata, got.wdata);
                    end
                end
            end else if (dones == 0 && !busy) begin
                busy_bad++;
            end
            if (dones > 0 && c == done_at + 1) check_eq({name, "_busy_off"}, 64'(busy), 64'd0);
            if (dones > 0 && c >= done_at + 3) break;
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        if (dones == 0) begin
            check_eq({name, "_done_seen"}, 64'd0, 64'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        check_eq({name, "_ndone"}, 64'(dones), 64'd1);
        check_eq({name, "_stable"}, 64'(req_bad), 64'd0);
        check_eq({name, "_busy_hold"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        int rq;
        int nd;
        n_chk = 0; n_err = 0; m_valm = '0;
        reset = 1'b1; start = 1'b0; icode = '0; ValA = '0; ValE = '0; ValP = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 64'(mem_req), 64'd0);
        check_eq("rst_we", 64'(mem_we), 64'd0);
        check_eq("rst_addr", mem_addr, 64'd0);
        check_eq("rst_wdata", mem_wdata, 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_valm", ValM, 64'd0);
        check_eq("rst_err", 64'(adr_error), 64'd0);
        reset = 1'b0;

        run_cmd("mrmovq", 4'd5, 64'h5, 64'h40, 64'h9, 2, 64'hDEADBEEF, 2);
        run_cmd("call", 4'd8, 64'h77, 64'h1F8, 64'h123, 1, 64'h5555, 0);
        run_cmd("pop_oob", 4'd11, 64'd8193, 64'h10, 64'h0, 1, 64'h1111, 0);
        run_cmd("pop_lim", 4'd11, 64'd8192, 64'h10, 64'h0, 3, 64'hCAFE, 0);
        run_cmd("tmo", 4'd4, 64'hAB, 64'h10, 64'h0, -1, 64'h0, 0);
        run_cmd("noacc", 4'd6, 64'h1, 64'h2, 64'h3, 1, 64'h2222, 0);
        run_cmd("ret", 4'd9, 64'h88, 64'h4000, 64'h0, 1, 64'h0123456789ABCDEF, 0);
        run_cmd("push_lastack", 4'd10, 64'h77, 64'h100, 64'h0, 16, 64'h3333, 0);
        run_cmd("rm_huge", 4'd4, 64'h1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 64'h0, 0);

        // Reset in the 3rd REQ cycle, then a stray ack that must be ignored.
        @(posedge clk); #1;
        start = 1'b1; icode = 4'd5; ValE = 64'h80;
        @(posedge clk); #1;
        start = 1'b0;
        rq = 0;
        for (int c = 1; c <= 10 && rq < 3; c++) begin
            @(negedge clk);
            if (mem_req) rq++;
        end
        check_eq("rstreq_cycles", 64'(rq), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hBAD0BAD0;
        m_valm = '0;
        check_eq("rstreq_req", 64'(mem_req), 64'd0);
        check_eq("rstreq_addr", mem_addr, 64'd0);
        check_eq("rstreq_busy", 64'(busy), 64'd0);
        check_eq("rstreq_valm", ValM, m_valm);
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (done || mem_req) nd++;
        end
        check_eq("rstreq_quiet", 64'(nd), 64'd0);
        check_eq("rstreq_valm_end", ValM, m_valm);
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Initiator side of the SEQ/PIPE data-memory interface.
- Takes a memory-stage command (icode, ValA, ValE, ValP) and drives a req/ack handshake to a multi-cycle data-memory responder.
- Returns ValM and a done pulse, and flags bad addresses and timeouts as adr_error.
- Sits between execute and a stallable data memory; busy drives the pipeline stall.

Parameters:
- MEM_LIMIT, 8192: highest legal word address; any address > MEM_LIMIT is an error.
- TIMEOUT, 16: max REQ cycles without mem_ack before the error path is taken.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command valid; sampled only in IDLE
- icode  in  4  Y86 instruction code
- ValA  in  64  operand A (store data, or ret/popq address)
- ValE  in  64  execute result (address)
- ValP  in  64  next PC (call store data)
- mem_req  out  1  request valid to memory
- mem_we  out  1  1=write, 0=read
- mem_addr  out  64  word address
- mem_wdata  out  64  write data
- mem_ack  in  1  responder completion, 1 cycle
- mem_rdata  in  64  read data, valid with mem_ack
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- ValM  out  64  read result
- adr_error  out  1  address or timeout error

Behaviour:
- Reset (sync, active-high): state=IDLE. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, ValM=0, adr_error=0, counter=0. Reset during REQ drops mem_req at that edge; the in-flight ack is ignored.
- All outputs are registered.
- Access decode, latched at start:
  - icode 4 (rmmovq): write ValE <- ValA
  - icode 5 (mrmovq): read ValE
  - icode 8 (call): write ValE <- ValP
  - icode 9 (ret): read ValA
  - icode 10 (pushq): write ValE <- ValA
  - icode 11 (popq): read ValA
  - any other icode: no access.
- IDLE:
  - On start, latch decode. At the same edge: adr_error <- 0 and busy asserts.
  - No access -> DONE.
  - Address > MEM_LIMIT -> ERR, with no request issued.
  - Otherwise -> REQ, with mem_req=1, mem_we/mem_addr/mem_wdata loaded and counter=0.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until ack.
  - mem_ack=1: for a read, ValM <- mem_rdata. mem_req <- 0, go to DONE.
  - No ack: counter+1. When counter reaches TIMEOUT-1 with no ack -> ERR, mem_req <- 0.
  - Ack in the same cycle as timeout: ack wins.
- DONE: done=1 for exactly one cycle, then IDLE. Minimum latency start->done:
  - 2 cycles with no access.
  - 3 cycles with a same-cycle ack, i.e. mem_ack in the first REQ cycle.
- ERR: done=1 and adr_error=1 for one cycle, then IDLE. adr_error holds until the next accepted start. ValM is unchanged.
- Writes leave ValM unchanged.
- start while busy is ignored; no queueing.
- mem_ack outside REQ is ignored.
- Address compare is unsigned 64-bit, strict greater-than (MEM_LIMIT itself is legal).

Decomposition:
- Shared package y86_pkg:
  - icode constants: IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - state encoding: IDLE, REQ, DONE, ERR.
  - MEM_LIMIT default.
- Sub-module mem_access_decode: combinational icode -> {is_rd, is_wr, addr_sel, data_sel}. Shared with the memory responder and the pipeline hazard unit.

Test Plan:
- mrmovq: icode=5, ValE=0x40, responder acks with rdata=0xDEADBEEF on the 2nd REQ cycle -> mem_req/we=0/addr=0x40 stable until ack, ValM=0xDEADBEEF, done pulses 1 cycle, busy drops after it.
- call: icode=8, ValE=0x1F8, ValP=0x123 -> mem_we=1, mem_addr=0x1F8, mem_wdata=0x123; ValM unchanged after ack.
- Bounds: icode=11, ValA=8193 -> no mem_req, adr_error=1 and done pulse 2 cycles after start. Repeat with ValA=8192 -> normal read issued.
- Timeout: icode=4, ValE=0x10, mem_ack never asserted -> mem_req high exactly TIMEOUT cycles, then adr_error=1 and done; next start clears adr_error.
- No access: icode=6 -> no mem_req, done at start+2. A start pulsed while busy during an earlier mrmovq is ignored; exactly one done is seen.
- Reset mid-REQ: assert reset in the 3rd REQ cycle, then mem_ack next cycle -> all outputs 0 after the reset edge, ValM=0, no done.
